// File: rtl/key_expansion_multi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : key_expansion_multi_pkg
// Description : Shared AES key-schedule constants, FSM encodings and GF(2^8)
//               helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package key_expansion_multi_pkg;

  localparam logic [1:0] c_key_len_128 = 2'b00;
  localparam logic [1:0] c_key_len_192 = 2'b01;
  localparam logic [1:0] c_key_len_256 = 2'b10;
  localparam logic [1:0] c_key_len_bad = 2'b11;

  localparam logic [3:0] c_nk_128 = 4'd4;
  localparam logic [3:0] c_nk_192 = 4'd6;
  localparam logic [3:0] c_nk_256 = 4'd8;
  localparam logic [3:0] c_nr_128 = 4'd10;
  localparam logic [3:0] c_nr_192 = 4'd12;
  localparam logic [3:0] c_nr_256 = 4'd14;

  localparam logic [7:0] c_rcon_init = 8'h01;

  localparam logic [1:0] c_st_idle   = 2'd0;
  localparam logic [1:0] c_st_expand = 2'd1;
  localparam logic [1:0] c_st_finish = 2'd2;

  function automatic logic [3:0] nk_of(input logic [1:0] key_len);
    case (key_len)
      c_key_len_192: return c_nk_192;
      c_key_len_256: return c_nk_256;
      default:       return c_nk_128;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input logic [1:0] key_len);
    case (key_len)
      c_key_len_192: return c_nr_192;
      c_key_len_256: return c_nr_256;
      default:       return c_nr_128;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_sbox.sv
`default_nettype none
// ============================================================================
// Module      : aes_sbox
// Description : Combinational AES S-box (multiplicative inverse + affine map).
// Revision    : 1.0 - initial release
// ============================================================================
module aes_sbox
  import key_expansion_multi_pkg::*;
(
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  logic [7:0] w_sq;
  logic [7:0] w_inv;

  // x^254 = x^-1 in GF(2^8); also maps 0 to 0 as the S-box requires
  always_comb begin
    w_sq  = i_byte;
    w_inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      w_sq  = gf_mul(w_sq, w_sq);
      w_inv = gf_mul(w_inv, w_sq);
    end
  end

  assign o_byte = w_inv
                ^ {w_inv[6:0], w_inv[7]}
                ^ {w_inv[5:0], w_inv[7:6]}
                ^ {w_inv[4:0], w_inv[7:5]}
                ^ {w_inv[3:0], w_inv[7:4]}
                ^ 8'h63;

endmodule
`default_nettype wire

// File: rtl/key_expansion_multi.sv
`default_nettype none
// ============================================================================
// Module      : key_expansion_multi
// Description : Iterative AES-128/192/256 key expansion, one word per cycle,
//               with random-access round-key readout.
// Revision    : 1.0 - initial release
// ============================================================================
module key_expansion_multi
  import key_expansion_multi_pkg::*;
#(
  parameter int MAX_NK = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            key_len,
  input  logic [0:32*MAX_NK-1]  initial_key,
  input  logic [3:0]            rk_addr,
  output logic [0:127]          rk_data,
  output logic                  busy,
  output logic                  done,
  output logic                  key_valid,
  output logic                  err
);

  localparam int         c_num_words = 4 * (MAX_NK + 7);
  localparam logic [3:0] c_max_nk    = 4'(MAX_NK);

  logic [1:0]  r_state;
  logic [3:0]  r_nk;
  logic [3:0]  r_nr;
  logic [3:0]  r_mod;
  logic [5:0]  r_idx;
  logic [7:0]  r_rcon;
  logic        r_busy;
  logic        r_done;
  logic        r_key_valid;
  logic        r_err;

  logic [c_num_words-1:0][31:0] r_w;
  logic [c_num_words-1:0][31:0] w_w_next;

  logic [3:0]  w_nk_req;
  logic        w_start_ok;
  logic        w_accept;
  logic        w_gen;
  logic [31:0] w_prev;
  logic [31:0] w_back;
  logic        w_rot_case;
  logic        w_sub_case;
  logic [31:0] w_sbox_in;
  logic [31:0] w_sub;
  logic [31:0] w_temp;
  logic [31:0] w_new;
  logic [5:0]  w_base;

  assign w_nk_req   = nk_of(key_len);
  assign w_start_ok = (key_len != c_key_len_bad) && (w_nk_req <= c_max_nk);
  assign w_accept   = !reset && (r_state == c_st_idle) && start && w_start_ok;
  assign w_gen      = !reset && (r_state == c_st_expand);

  assign w_prev     = r_w[r_idx - 6'd1];
  assign w_back     = r_w[r_idx - {2'b00, r_nk}];
  assign w_rot_case = (r_mod == 4'd0);
  assign w_sub_case = (r_nk == c_nk_256) && (r_mod == 4'd4);
  assign w_sbox_in  = w_rot_case ? {w_prev[23:0], w_prev[31:24]} : w_prev;

  for (genvar k = 0; k < 4; k++) begin : g_sbox
    aes_sbox u_sbox (
      .i_byte (w_sbox_in[8*k +: 8]),
      .o_byte (w_sub[8*k +: 8])
    );
  end

  assign w_temp = w_rot_case ? (w_sub ^ {r_rcon, 24'h000000}) :
                  w_sub_case ? w_sub : w_prev;
  assign w_new  = w_back ^ w_temp;

  always_comb begin
    w_w_next = r_w;
    if (w_accept) begin
      for (int j = 0; j < MAX_NK; j++) begin
        if (j < int'(w_nk_req)) w_w_next[6'(j)] = initial_key[32*j +: 32];
      end
    end else if (w_gen) begin
      w_w_next[r_idx] = w_new;
    end
  end

  // Word storage carries no reset; key_valid qualifies its contents
  always_ff @(posedge clk) begin
    r_w <= w_w_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= c_st_idle;
      r_nk        <= c_nk_128;
      r_nr        <= c_nr_128;
      r_mod       <= 4'd0;
      r_idx       <= 6'd0;
      r_rcon      <= c_rcon_init;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_key_valid <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        c_st_idle: begin
          if (start) begin
            if (w_start_ok) begin
              r_nk        <= w_nk_req;
              r_nr        <= nr_of(key_len);
              r_idx       <= {2'b00, w_nk_req};
              r_mod       <= 4'd0;
              r_rcon      <= c_rcon_init;
              r_key_valid <= 1'b0;
              r_busy      <= 1'b1;
              r_state     <= c_st_expand;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        c_st_expand: begin
          r_idx <= r_idx + 6'd1;
          r_mod <= (r_mod == r_nk - 4'd1) ? 4'd0 : r_mod + 4'd1;
          if (w_rot_case) r_rcon <= xtime(r_rcon);
          // Last word index is 4*(Nr+1)-1 = {Nr, 2'b11}
          if (r_idx == {r_nr, 2'b11}) r_state <= c_st_finish;
        end
        c_st_finish: begin
          r_busy      <= 1'b0;
          r_done      <= 1'b1;
          r_key_valid <= 1'b1;
          r_state     <= c_st_idle;
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

  assign w_base = {rk_addr, 2'b00};

  always_comb begin
    rk_data = '0;
    if (rk_addr <= r_nr) begin
      rk_data = {r_w[w_base], r_w[w_base + 6'd1], r_w[w_base + 6'd2], r_w[w_base + 6'd3]};
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign key_valid = r_key_valid;
  assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_key_expansion_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_expansion_multi
// Description : Self-checking bench for key_expansion_multi against a
//               FIPS-197 style reference key schedule.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_expansion_multi;

  logic          clk = 1'b0;
  logic          reset;
  logic          start, start6;
  logic [1:0]    key_len, key_len6;
  logic [0:255]  initial_key;
  logic [0:191]  initial_key6;
  logic [3:0]    rk_addr, rk_addr6;
  logic [0:127]  rk_data, rk_data6;
  logic          busy, done, key_valid, err;
  logic          busy6, done6, key_valid6, err6;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  m_sbox [256];
  logic [7:0]  rcon_tab [11] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  logic [31:0] m_w [60];
  int          m_nk, m_nr;

  localparam logic [255:0] c_k128 = {128'h0f1571c947d9e8590cb7add6af7f6798, 128'h0};
  localparam logic [255:0] c_k192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] c_k256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] c_rk128 = 128'hb48ef352ba98134e7f4d592086261876;
  localparam logic [127:0] c_rk192 = 128'ha4970a331a78dc09c418c271e3a41d5d;
  localparam logic [127:0] c_rk256 = 128'h24fc79ccbf0979e9371ac23c6d68de36;

  key_expansion_multi #(.MAX_NK(8)) u_dut (
    .clk(clk), .reset(reset), .start(start), .key_len(key_len),
    .initial_key(initial_key), .rk_addr(rk_addr), .rk_data(rk_data),
    .busy(busy), .done(done), .key_valid(key_valid), .err(err)
  );

  key_expansion_multi #(.MAX_NK(6)) u_dut6 (
    .clk(clk), .reset(reset), .start(start6), .key_len(key_len6),
    .initial_key(initial_key6), .rk_addr(rk_addr6), .rk_data(rk_data6),
    .busy(busy6), .done(done6), .key_valid(key_valid6), .err(err6)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int rotl8(input int x, input int s);
    return ((x << s) | (x >> (8 - s))) & 255;
  endfunction

  // S-box table built by walking the multiplicative group with generator 3
  task automatic init_sbox();
    int p, q, x;
    p = 1;
    q = 1;
    do begin
      p = (p ^ (p << 1) ^ (((p & 128) != 0) ? 27 : 0)) & 255;
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      q = q & 255;
      if ((q & 128) != 0) q = q ^ 9;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4) ^ 99;
      m_sbox[p] = 8'(x);
    end while (p != 1);
    m_sbox[0] = 8'h63;
  endtask

  function automatic logic [31:0] m_subword(input logic [31:0] x);
    return {m_sbox[x[31:24]], m_sbox[x[23:16]], m_sbox[x[15:8]], m_sbox[x[7:0]]};
  endfunction

  task automatic model_expand(input logic [255:0] k, input int kl);
    logic [31:0] t;
    m_nk = 4 + 2 * kl;
    m_nr = m_nk + 6;
    for (int i = 0; i < m_nk; i++) m_w[i] = k[255 - 32*i -: 32];
    for (int i = m_nk; i < 4 * (m_nr + 1); i++) begin
      t = m_w[i-1];
      if (i % m_nk == 0)
        t = m_subword({t[23:0], t[31:24]}) ^ {rcon_tab[i / m_nk], 24'h0};
      else if (m_nk == 8 && i % 8 == 4)
        t = m_subword(t);
      m_w[i] = m_w[i - m_nk] ^ t;
    end
  endtask

  function automatic logic [127:0] m_rk(input int r);
    return {m_w[4*r], m_w[4*r+1], m_w[4*r+2], m_w[4*r+3]};
  endfunction

  task automatic run_expand(input logic [1:0] kl, input logic [255:0] k, output int lat);
    key_len     = kl;
    initial_key = k;
    start       = 1'b1;
    tick();
    start = 1'b0;
    lat   = 0;
    while (!done && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  task automatic verify_all(input string tag);
    for (int r = 0; r <= m_nr; r++) begin
      rk_addr = 4'(r);
      #1;
      check($sformatf("%s_rk%0d", tag, r), rk_data, m_rk(r));
    end
    if (m_nr < 15) begin
      rk_addr = 4'(m_nr + 1);
      #1;
      check($sformatf("%s_rk_oob", tag), rk_data, 128'h0);
    end
    tick();
  endtask

  task automatic run_vector(input string tag, input logic [1:0] kl, input logic [255:0] k,
                            input int rk_idx, input logic [127:0] rk_exp);
    int lat;
    model_expand(k, int'(kl));
    run_expand(kl, k, lat);
    check({tag, "_latency"}, lat, 4 * (m_nr + 1) - m_nk + 1);
    check({tag, "_busy_low"}, busy, 1'b0);
    check({tag, "_key_valid"}, key_valid, 1'b1);
    tick();
    check({tag, "_done_one_cycle"}, done, 1'b0);
    rk_addr = 4'(rk_idx);
    #1;
    check({tag, "_vector"}, rk_data, rk_exp);
    verify_all(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, n_done, n_err, kl;
    logic [255:0] rk;

    init_sbox();
    reset = 1'b1;
    start = 1'b0;   start6 = 1'b0;
    key_len = 2'b00; key_len6 = 2'b00;
    initial_key = '0; initial_key6 = '0;
    rk_addr = 4'd0; rk_addr6 = 4'd0;
    repeat (3) tick();
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_key_valid", key_valid, 1'b0);
    check("reset_err", err, 1'b0);
    reset = 1'b0;
    tick();

    run_vector("aes128", 2'b00, c_k128, 10, c_rk128);
    run_vector("aes192", 2'b01, c_k192, 12, c_rk192);
    run_vector("aes256", 2'b10, c_k256, 14, c_rk256);

    // Illegal key length must not disturb the stored 256-bit schedule
    key_len = 2'b11;
    start   = 1'b1;
    tick();
    start = 1'b0;
    check("illegal_err_pulse", err, 1'b1);
    check("illegal_busy", busy, 1'b0);
    tick();
    check("illegal_err_clear", err, 1'b0);
    check("illegal_key_valid", key_valid, 1'b1);
    rk_addr = 4'd14;
    #1;
    check("illegal_rk_kept", rk_data, c_rk256);
    tick();

    // MAX_NK=6 instance: 192-bit works, 256-bit is rejected
    key_len6     = 2'b01;
    initial_key6 = c_k192[255:64];
    start6       = 1'b1;
    tick();
    start6 = 1'b0;
    lat = 0;
    while (!done6 && lat < 200) begin
      tick();
      lat++;
    end
    check("nk6_latency", lat, 47);
    rk_addr6 = 4'd12;
    #1;
    check("nk6_vector", rk_data6, c_rk192);
    tick();
    key_len6 = 2'b10;
    start6   = 1'b1;
    tick();
    start6 = 1'b0;
    check("nk6_reject_err", err6, 1'b1);
    check("nk6_reject_busy", busy6, 1'b0);
    tick();
    check("nk6_reject_err_clear", err6, 1'b0);
    check("nk6_reject_key_valid", key_valid6, 1'b1);
    check("nk6_reject_rk_kept", rk_data6, c_rk192);

    // Reset in the middle of an expansion
    key_len     = 2'b00;
    initial_key = c_k128;
    start       = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    check("abort_busy_before", busy, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_key_valid", key_valid, 1'b0);
    check("abort_done", done, 1'b0);
    n_done = 0;
    repeat (60) begin
      tick();
      if (done) n_done++;
    end
    check("abort_no_done", n_done, 0);
    run_vector("restart128", 2'b00, c_k128, 10, c_rk128);

    // Start held high during expansion is ignored
    key_len     = 2'b00;
    initial_key = c_k128;
    start       = 1'b1;
    tick();
    n_done = 0;
    n_err  = 0;
    repeat (20) begin
      tick();
      if (done) n_done++;
      if (err) n_err++;
    end
    start = 1'b0;
    repeat (60) begin
      tick();
      if (done) n_done++;
      if (err) n_err++;
    end
    check("restart_ignored_done_count", n_done, 1);
    check("restart_ignored_err_count", n_err, 0);
    rk_addr = 4'd11;
    #1;
    check("aes128_rk11_zero", rk_data, 128'h0);
    rk_addr = 4'd10;
    #1;
    check("restart_ignored_vector", rk_data, c_rk128);
    tick();

    // Randomized keys across all legal lengths
    for (int it = 0; it < 8; it++) begin
      kl = int'($urandom_range(0, 2));
      for (int b = 0; b < 8; b++) rk[32*b +: 32] = $urandom;
      model_expand(rk, kl);
      run_expand(2'(kl), rk, lat);
      check($sformatf("rand%0d_latency", it), lat, 4 * (m_nr + 1) - m_nk + 1);
      check($sformatf("rand%0d_key_valid", it), key_valid, 1'b1);
      verify_all($sformatf("rand%0d", it));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/key_expansion_multi.md
KEY_EXPANSION_MULTI -- requirements
Module: key_expansion_multi

Interface
REQ-001 SHALL have parameter MAX_NK, default 8, meaning the largest key length in 32-bit words the instance supports (legal values 4, 6, 8).
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request a new expansion; sampled only in IDLE.
REQ-005 SHALL have port key_len  input  2  key length: 00=128-bit (Nk=4, Nr=10), 01=192-bit (Nk=6, Nr=12), 10=256-bit (Nk=8, Nr=14), 11=illegal.
REQ-006 SHALL have port initial_key  input  [0:32*MAX_NK-1]  cipher key, big-endian, left-aligned; unused trailing bits ignored.
REQ-007 SHALL have port rk_addr  input  4  round-key index 0..Nr.
REQ-008 SHALL have port rk_data  output  [0:127]  round key rk_addr, i.e. words w[4*rk_addr]..w[4*rk_addr+3], w[4*rk_addr] at bits [0:31].
REQ-009 SHALL have port busy  output  1  high while expanding.
REQ-010 SHALL have port done  output  1  one-cycle pulse on completion.
REQ-011 SHALL have port key_valid  output  1  high while stored schedule is complete and consistent.
REQ-012 SHALL have port err  output  1  one-cycle pulse on rejected start.

Function
REQ-013 SHALL implement FSM states IDLE, EXPAND, FINISH; IDLE->EXPAND on legal start; EXPAND->FINISH after last word; FINISH->IDLE unconditionally.
REQ-014 SHALL treat start as legal when key_len != 11 and Nk <= MAX_NK; otherwise pulse err for one cycle, stay IDLE, retain stored words and key_valid.
REQ-015 SHALL, on the edge accepting start, latch Nk/Nr, load w[0]..w[Nk-1] from initial_key, clear key_valid, set busy.
REQ-016 SHALL generate exactly one word w[i] per cycle in EXPAND, i from Nk to 4*(Nr+1)-1 (44/52/60 words total).
REQ-017 SHALL compute w[i] = w[i-Nk] XOR temp, temp = SubWord(RotWord(w[i-1])) XOR Rcon[i/Nk] when i mod Nk = 0; SubWord(w[i-1]) when Nk=8 and i mod 8 = 4; else w[i-1].
REQ-018 SHALL generate Rcon sequentially (01, then GF(2^8) xtime per use: 01,02,04,08,10,20,40,80,1B,36), reset to 01 at each accepted start.
REQ-019 SHALL assert done and key_valid, deassert busy, in the cycle after the last word is written: done high 41/47/53 cycles after the accepting edge for 128/192/256.
REQ-020 SHALL ignore start while busy or in FINISH; no restart, no err.
REQ-021 SHALL drive rk_data combinationally from storage; rk_addr > latched Nr returns all zeros; reads during EXPAND return current (partial) contents.
REQ-022 SHALL allow start in the same cycle FINISH returns to IDLE to be sampled on the following edge only.

Reset
REQ-023 SHALL, on reset, force IDLE, busy=0, done=0, err=0, key_valid=0, Rcon=01, word index=0; word storage need not be cleared.
REQ-024 SHALL abort an in-progress expansion on reset; no done pulse is produced for the aborted run.

Structure
REQ-025 SHALL place key-length encodings, Nk/Nr lookup constants, Rcon initial value and FSM state encodings in a shared AES package.
REQ-026 SHALL instantiate four copies of one combinational sub-module aes_sbox (8-bit in, 8-bit out) for SubWord.
REQ-027 SHALL store 4*(MAX_NK+7) words when MAX_NK=8 (60) and scale storage to the largest supported mode otherwise.

Verification
REQ-028 SHALL check key_len=00, key 0f1571c947d9e8590cb7add6af7f6798 -> rk_addr=10 gives b48ef352ba98134e7f4d592086261876, done 41 cycles after start.
REQ-029 SHALL check key_len=01, key 000102..17 -> rk_addr=12 gives a4970a331a78dc09c418c271e3a41d5d, done after 47 cycles.
REQ-030 SHALL check key_len=10, key 000102..1f -> rk_addr=14 gives 24fc79ccbf0979e9371ac23c6d68de36, done after 53 cycles.
REQ-031 SHALL check key_len=11 (and key_len=10 with MAX_NK=6) -> err pulses one cycle, busy stays 0, prior key_valid and rk_data unchanged.
REQ-032 SHALL check reset asserted mid-EXPAND -> next cycle IDLE, key_valid=0, no done; restart then yields correct 128-bit vector.
REQ-033 SHALL check start re-asserted during EXPAND -> ignored, single done pulse, rk_addr=11 in 128-bit mode returns zero.
